// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the single-issue RV32 datapath: sequences IF/ID/EX/MEM/WB,
// decodes the instruction into datapath controls and aborts stalled data-memory accesses into ERR.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dmem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic        mem_error,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_ERR = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [CW-1:0] cnt_r;
  logic          mem_error_r;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       f7_zero_s;
  logic       f7_alt_s;
  logic       unused_bits_s;

  logic       is_rtype_s, is_ialu_s, is_lw_s, is_sw_s, is_beq_s;
  logic       is_legal_s, is_mem_op_s;
  logic       raw_alu_src_s, raw_mem_to_reg_s;
  logic [3:0] raw_alu_ctrl_s;
  logic       dec_alu_src_s, dec_mem_to_reg_s;
  logic [3:0] dec_alu_ctrl_s;

  assign opcode_s      = instr[6:0];
  assign funct3_s      = instr[14:12];
  assign f7_zero_s     = (instr[31:25] == 7'b0000000);
  assign f7_alt_s      = (instr[31:25] == 7'b0100000);
  assign unused_bits_s = ^{instr[24:15], instr[11:7]};

  // Instruction decode: classify the opcode/funct combination and pick the ALU setup.
  always_comb begin
    is_rtype_s       = 1'b0;
    is_ialu_s        = 1'b0;
    is_lw_s          = 1'b0;
    is_sw_s          = 1'b0;
    is_beq_s         = 1'b0;
    raw_alu_src_s    = 1'b0;
    raw_mem_to_reg_s = 1'b0;
    raw_alu_ctrl_s   = ALU_AND;
    case (opcode_s)
      OP_R: begin
        case (funct3_s)
          3'b000: begin
            is_rtype_s     = f7_zero_s | f7_alt_s;
            raw_alu_ctrl_s = f7_alt_s ? ALU_SUB : ALU_ADD;
          end
          3'b001: begin is_rtype_s = f7_zero_s; raw_alu_ctrl_s = ALU_SLL; end
          3'b010: begin is_rtype_s = f7_zero_s; raw_alu_ctrl_s = ALU_SLT; end
          3'b100: begin is_rtype_s = f7_zero_s; raw_alu_ctrl_s = ALU_XOR; end
          3'b101: begin
            is_rtype_s     = f7_zero_s | f7_alt_s;
            raw_alu_ctrl_s = f7_alt_s ? ALU_SRA : ALU_SRL;
          end
          3'b110: begin is_rtype_s = f7_zero_s; raw_alu_ctrl_s = ALU_OR;  end
          3'b111: begin is_rtype_s = f7_zero_s; raw_alu_ctrl_s = ALU_AND; end
          default: is_rtype_s = 1'b0;
        endcase
      end
      OP_I: begin
        raw_alu_src_s = 1'b1;
        case (funct3_s)
          3'b000: begin is_ialu_s = 1'b1; raw_alu_ctrl_s = ALU_ADD; end
          3'b010: begin is_ialu_s = 1'b1; raw_alu_ctrl_s = ALU_SLT; end
          3'b100: begin is_ialu_s = 1'b1; raw_alu_ctrl_s = ALU_XOR; end
          3'b110: begin is_ialu_s = 1'b1; raw_alu_ctrl_s = ALU_OR;  end
          3'b111: begin is_ialu_s = 1'b1; raw_alu_ctrl_s = ALU_AND; end
          3'b001: begin is_ialu_s = f7_zero_s; raw_alu_ctrl_s = ALU_SLL; end
          3'b101: begin
            is_ialu_s      = f7_zero_s | f7_alt_s;
            raw_alu_ctrl_s = f7_alt_s ? ALU_SRA : ALU_SRL;
          end
          default: is_ialu_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        is_lw_s          = (funct3_s == 3'b010);
        raw_alu_src_s    = 1'b1;
        raw_mem_to_reg_s = 1'b1;
        raw_alu_ctrl_s   = ALU_ADD;
      end
      OP_STORE: begin
        is_sw_s        = (funct3_s == 3'b010);
        raw_alu_src_s  = 1'b1;
        raw_alu_ctrl_s = ALU_ADD;
      end
      OP_BRANCH: begin
        is_beq_s       = (funct3_s == 3'b000);
        raw_alu_ctrl_s = ALU_SUB;
      end
      default: is_beq_s = 1'b0;
    endcase
  end

  // An illegal instruction behaves as a NOP, so its decode outputs read as zero.
  assign is_legal_s       = is_rtype_s | is_ialu_s | is_lw_s | is_sw_s | is_beq_s;
  assign is_mem_op_s      = is_lw_s | is_sw_s;
  assign dec_alu_src_s    = is_legal_s & raw_alu_src_s;
  assign dec_mem_to_reg_s = is_legal_s & raw_mem_to_reg_s;
  assign dec_alu_ctrl_s   = is_legal_s ? raw_alu_ctrl_s : 4'b0000;

  // State register, memory timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IF;
      cnt_r       <= '0;
      mem_error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_MEM && is_mem_op_s && !dmem_ready) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      if (next_state_s == S_ERR) begin
        mem_error_r <= 1'b1;
      end else begin
        mem_error_r <= mem_error_r;
      end
    end
  end

  // Next-state logic; ready on the final allowed MEM cycle still completes the access.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IF:  next_state_s = S_ID;
      S_ID:  next_state_s = S_EX;
      S_EX:  next_state_s = S_MEM;
      S_MEM: begin
        if (!is_mem_op_s || dmem_ready) begin
          next_state_s = S_WB;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = S_ERR;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB:  next_state_s = S_IF;
      S_ERR: next_state_s = S_ERR;
      default: next_state_s = S_IF;
    endcase
  end

  // Control outputs per state; IF, ERR and unused encodings leave everything low.
  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = 4'b0000;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    case (state_r)
      S_ID: begin
        ALUSrc   = dec_alu_src_s;
        MemToReg = dec_mem_to_reg_s;
        ALUCtrl  = dec_alu_ctrl_s;
        illegal  = ~is_legal_s;
      end
      S_EX: begin
        ALUSrc   = dec_alu_src_s;
        MemToReg = dec_mem_to_reg_s;
        ALUCtrl  = dec_alu_ctrl_s;
      end
      S_MEM: begin
        ALUSrc   = dec_alu_src_s;
        MemToReg = dec_mem_to_reg_s;
        ALUCtrl  = dec_alu_ctrl_s;
        MemRead  = is_lw_s;
        MemWrite = is_sw_s;
      end
      S_WB: begin
        ALUSrc   = dec_alu_src_s;
        MemToReg = dec_mem_to_reg_s;
        ALUCtrl  = dec_alu_ctrl_s;
        loadPC   = 1'b1;
        RegWrite = is_rtype_s | is_ialu_s | is_lw_s;
        PCSrc    = is_beq_s & Zero;
      end
      default: illegal = 1'b0;
    endcase
  end

  assign state     = state_r;
  assign mem_error = mem_error_r;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM that sequences the single-issue RV32 datapath.
- Decodes the current instruction word and drives the datapath controls: PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC.
- Drives data-memory read/write strobes and waits on a data-memory ready handshake.
- Fixed 5-state sequence per instruction; data-memory wait states are added only in MEM.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in MEM without dmem_ready before the FSM aborts into ERR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word at the current PC.
- Zero  in  1  ALU zero flag from the datapath.
- dmem_ready  in  1  data memory has completed the MemRead/MemWrite access this cycle.
- PCSrc  out  1  selects branch target for the next PC.
- ALUSrc  out  1  selects the ALU op2 source: 1 = immediate, 0 = rs2.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  write-back source: 1 = dReadData, 0 = ALU result.
- ALUCtrl  out  4  ALU operation code.
- loadPC  out  1  PC update enable.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- illegal  out  1  one-cycle pulse: unsupported instruction was decoded.
- mem_error  out  1  sticky: data-memory timeout occurred.
- state  out  3  debug encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.

Behaviour:
- Reset:
  - The next rising edge with rst=1 forces state to IF and clears the timeout counter and mem_error.
  - All outputs are 0 in IF, including after reset.
  - rst has priority over every transition, including a reset asserted mid-MEM or in ERR.
  - No register or memory write occurs in the cycle following reset.
- Transitions:
  - IF->ID->EX->MEM->WB->IF, one cycle each, except MEM.
  - MEM holds while dmem_ready=0 for LW/SW. Non-memory instructions pass through MEM in one cycle and ignore dmem_ready.
  - Minimum CPI is 5.
- Decode outputs (ALUSrc, ALUCtrl, MemToReg):
  - Combinational from instr, valid and held constant in ID, EX, MEM and WB, so dAddress and WriteBackData stay stable.
  - Forced to 0 in IF and ERR.
  - instr is stable from ID through WB because PC changes only at the WB edge.
- ALUCtrl encoding:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
  - R-type (0110011): funct3/funct7[5] select ADD/SUB/SLL/SLT/XOR/SRL/SRA/OR/AND.
  - I-ALU (0010011): ADDI/SLTI/XORI/ORI/ANDI/SLLI/SRLI/SRAI; ALUSrc=1. For shift-immediates, funct7[5] selects SRAI.
  - LW (0000011, funct3=010) and SW (0100011, funct3=010): ADD, ALUSrc=1.
  - BEQ (1100011, funct3=000): SUB, ALUSrc=0.
- Illegal instructions:
  - Any other opcode/funct combination is illegal.
  - illegal pulses high for exactly one cycle in ID.
  - The instruction then executes as a NOP: no RegWrite, no MemRead/MemWrite, PC+4.
- MEM state:
  - MemRead=1 (LW) or MemWrite=1 (SW) for every cycle spent in MEM, deasserted on the cycle after dmem_ready is sampled high.
  - A timeout counter increments each MEM cycle with dmem_ready=0.
  - If the counter reaches MEM_TIMEOUT, the next state is ERR, mem_error is set, and no writeback or PC update occurs.
  - dmem_ready on the same cycle the count reaches MEM_TIMEOUT counts as success: ready wins.
- WB state:
  - loadPC=1 for every instruction.
  - RegWrite=1 for R-type, I-ALU and LW.
  - MemToReg=1 for LW.
  - PCSrc = (BEQ & Zero), evaluated combinationally in WB.
  - Branch target arithmetic is the datapath's responsibility.
  - rd=x0 writes are still issued; the register file discards them.
- ERR state:
  - All control outputs are 0, mem_error=1.
  - The FSM stays in ERR until rst.
- No output is asserted outside the states listed above.

Test Plan:
1. rst=1 for 2 cycles, then ADD x3,x1,x2 (0x002081B3) -> state 0,1,2,3,4,0; ALUCtrl=0010, ALUSrc=0 in ID..WB; RegWrite=1 and loadPC=1 only in cycle 5; PCSrc=0.
2. LW x5,8(x1) (0x0080A283), dmem_ready low 3 cycles then high -> MemRead=1 for 4 cycles; ALUSrc=1, ALUCtrl=0010; WB asserts RegWrite=1, MemToReg=1, loadPC=1; CPI=8.
3. BEQ x1,x2,+16 with Zero=1, then repeated with Zero=0 -> ALUCtrl=0110; WB gives PCSrc=1/loadPC=1, then PCSrc=0/loadPC=1; RegWrite=0 in both cases.
4. SW x2,4(x1) (0x0020A223) with dmem_ready held 0 for MEM_TIMEOUT=16 cycles -> MemWrite=1 for 16 cycles; state=7 with mem_error=1 and no loadPC; after rst=1, state=0 and mem_error=0.
5. instr=0xFFFFFFFF -> illegal=1 for exactly 1 cycle (ID); RegWrite=MemRead=MemWrite=0 throughout; loadPC=1 with PCSrc=0 in WB.
6. rst asserted during MEM of an LW, with dmem_ready arriving on the same edge -> next state IF; no RegWrite/loadPC pulse; all outputs 0.
